// File: rtl/img_ddr_lat_mem_if.sv
// Bus bundle for the two independent ports of img_ddr_lat_mem.
// The master side issues requests; the slave side returns data and status.
interface img_ddr_lat_mem_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 19
);
  logic                  req_a, we_a, ready_a, busy_a, err_a;
  logic [ADDR_WIDTH-1:0] addr_a;
  logic [DATA_WIDTH-1:0] data_a, q_a;
  logic                  req_b, we_b, ready_b, busy_b, err_b;
  logic [ADDR_WIDTH-1:0] addr_b;
  logic [DATA_WIDTH-1:0] data_b, q_b;

  modport master (
    output req_a, we_a, addr_a, data_a, req_b, we_b, addr_b, data_b,
    input  q_a, ready_a, busy_a, err_a, q_b, ready_b, busy_b, err_b
  );
  modport slave (
    input  req_a, we_a, addr_a, data_a, req_b, we_b, addr_b, data_b,
    output q_a, ready_a, busy_a, err_a, q_b, ready_b, busy_b, err_b
  );
endinterface

// File: rtl/img_ddr_lat_mem.sv
// Dual-port word memory with DDR-like access latency (slow random, fast sequential).
// Define IMG_DDR_SEQ_FAST_EN to enable the sequential fast path; otherwise all accesses take RAND_LAT.
module img_ddr_lat_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 19,
  parameter int DEPTH      = 263169,
  parameter int RAND_LAT   = 7,
  parameter int SEQ_LAT    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  img_ddr_lat_mem_if.slave bus
);
  localparam int NP = 2;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

  logic                  req_i  [NP];
  logic                  we_i   [NP];
  logic [ADDR_WIDTH-1:0] addr_i [NP];
  logic [DATA_WIDTH-1:0] data_i [NP];

  state_e                state_q [NP], state_d [NP];
  logic [7:0]            cnt_q   [NP], cnt_d   [NP];
  logic [7:0]            lat_q   [NP], lat_d   [NP];
  logic [ADDR_WIDTH-1:0] addr_q  [NP], addr_d  [NP];
  logic                  we_q    [NP], we_d    [NP];
  logic [DATA_WIDTH-1:0] data_q  [NP], data_d  [NP];
  logic [DATA_WIDTH-1:0] q_q     [NP], q_d     [NP];
  logic                  ready_q [NP], ready_d [NP];
  logic                  busy_q  [NP], busy_d  [NP];
  logic                  err_q   [NP], err_d   [NP];
`ifdef IMG_DDR_SEQ_FAST_EN
  logic [ADDR_WIDTH-1:0] last_q     [NP], last_d     [NP];
  logic                  last_vld_q [NP], last_vld_d [NP];
`endif

  logic fin [NP], inr [NP], wr_now [NP];
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign req_i[0]  = bus.req_a;  assign req_i[1]  = bus.req_b;
  assign we_i[0]   = bus.we_a;   assign we_i[1]   = bus.we_b;
  assign addr_i[0] = bus.addr_a; assign addr_i[1] = bus.addr_b;
  assign data_i[0] = bus.data_a; assign data_i[1] = bus.data_b;

  assign bus.q_a = q_q[0];     assign bus.q_b = q_q[1];
  assign bus.ready_a = ready_q[0]; assign bus.ready_b = ready_q[1];
  assign bus.busy_a = busy_q[0];   assign bus.busy_b = busy_q[1];
  assign bus.err_a = err_q[0];     assign bus.err_b = err_q[1];

  // fin marks the edge that enters DONE; memory is written on that same edge.
  always_comb begin
    for (int p = 0; p < NP; p++) begin
      fin[p]    = (state_q[p] == S_WAIT) && (cnt_q[p] == lat_q[p] - 8'd1);
      inr[p]    = {1'b0, addr_q[p]} < DEPTH_W;
      wr_now[p] = fin[p] && we_q[p] && inr[p];
    end
  end

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      int o;
      o           = 1 - p;
      state_d[p]  = state_q[p];
      cnt_d[p]    = cnt_q[p];
      lat_d[p]    = lat_q[p];
      addr_d[p]   = addr_q[p];
      we_d[p]     = we_q[p];
      data_d[p]   = data_q[p];
      q_d[p]      = q_q[p];
      ready_d[p]  = ready_q[p];
      busy_d[p]   = busy_q[p];
      err_d[p]    = err_q[p];
`ifdef IMG_DDR_SEQ_FAST_EN
      last_d[p]     = last_q[p];
      last_vld_d[p] = last_vld_q[p];
`endif
      case (state_q[p])
        S_IDLE: if (req_i[p]) begin
          state_d[p] = S_WAIT;
          busy_d[p]  = 1'b1;
          cnt_d[p]   = 8'd0;
          addr_d[p]  = addr_i[p];
          we_d[p]    = we_i[p];
          data_d[p]  = data_i[p];
          lat_d[p]   = 8'(RAND_LAT);
`ifdef IMG_DDR_SEQ_FAST_EN
          // Widened compare: DEPTH-1 -> 0 never counts as sequential.
          if (last_vld_q[p] &&
              ({1'b0, addr_i[p]} == {1'b0, last_q[p]} + (ADDR_WIDTH+1)'(1)))
            lat_d[p] = 8'(SEQ_LAT);
          last_d[p]     = addr_i[p];
          last_vld_d[p] = 1'b1;
`endif
        end
        S_WAIT: if (fin[p]) begin
          state_d[p] = S_DONE;
          ready_d[p] = 1'b1;
          err_d[p]   = !inr[p];
          // Same-edge collision: A's write wins; a reader sees the writer's data.
          if (!inr[p])
            q_d[p] = '0;
          else if (wr_now[o] && addr_q[o] == addr_q[p] && (p == 1 || !we_q[p]))
            q_d[p] = data_q[o];
          else if (we_q[p])
            q_d[p] = data_q[p];
          else
            q_d[p] = mem[addr_q[p]];
        end else begin
          cnt_d[p] = cnt_q[p] + 8'd1;
        end
        S_DONE: begin
          state_d[p] = S_IDLE;
          ready_d[p] = 1'b0;
          busy_d[p]  = 1'b0;
          err_d[p]   = 1'b0;
        end
        default: state_d[p] = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NP; p++) begin
        state_q[p] <= S_IDLE;
        cnt_q[p]   <= '0;
        lat_q[p]   <= '0;
        addr_q[p]  <= '0;
        we_q[p]    <= 1'b0;
        data_q[p]  <= '0;
        q_q[p]     <= '0;
        ready_q[p] <= 1'b0;
        busy_q[p]  <= 1'b0;
        err_q[p]   <= 1'b0;
`ifdef IMG_DDR_SEQ_FAST_EN
        last_q[p]     <= '0;
        last_vld_q[p] <= 1'b0;
`endif
      end
    end else begin
      for (int p = 0; p < NP; p++) begin
        state_q[p] <= state_d[p];
        cnt_q[p]   <= cnt_d[p];
        lat_q[p]   <= lat_d[p];
        addr_q[p]  <= addr_d[p];
        we_q[p]    <= we_d[p];
        data_q[p]  <= data_d[p];
        q_q[p]     <= q_d[p];
        ready_q[p] <= ready_d[p];
        busy_q[p]  <= busy_d[p];
        err_q[p]   <= err_d[p];
`ifdef IMG_DDR_SEQ_FAST_EN
        last_q[p]     <= last_d[p];
        last_vld_q[p] <= last_vld_d[p];
`endif
      end
    end
  end

  // Storage is not reset; port A is written last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (wr_now[1]) mem[addr_q[1]] <= data_q[1];
    if (wr_now[0]) mem[addr_q[0]] <= data_q[0];
  end
endmodule

// File: tb/tb_img_ddr_lat_mem.sv
// Directed bench for img_ddr_lat_mem: vector table plus collision and reset sequences.
module tb_img_ddr_lat_mem;
  localparam int DW = 8, AW = 19, DEPTH = 263169, RL = 7;
`ifdef IMG_DDR_SEQ_FAST_EN
  localparam int SL = 1;
`else
  localparam int SL = 7;
`endif
  localparam logic [AW-1:0] TOP = AW'(DEPTH - 1);
  localparam logic [AW-1:0] OOR = AW'(DEPTH);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  img_ddr_lat_mem_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  img_ddr_lat_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
                    .RAND_LAT(RL), .SEQ_LAT(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit            port;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            lat;
    logic [DW-1:0] q;
    bit            err;
    bit            mid;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(bit p, bit req, bit we, logic [AW-1:0] a, logic [DW-1:0] d);
    if (!p) begin
      bus.req_a = req; bus.we_a = we; bus.addr_a = a; bus.data_a = d;
    end else begin
      bus.req_b = req; bus.we_b = we; bus.addr_b = a; bus.data_b = d;
    end
  endtask

  function automatic logic rdy(bit p);  return p ? bus.ready_b : bus.ready_a; endfunction
  function automatic logic bsy(bit p);  return p ? bus.busy_b  : bus.busy_a;  endfunction
  function automatic logic er(bit p);   return p ? bus.err_b   : bus.err_a;   endfunction
  function automatic logic [DW-1:0] qq(bit p); return p ? bus.q_b : bus.q_a; endfunction

  // Accept on a posedge; n counts negedges after acceptance, so ready shows at n == latency.
  task automatic run(vec_t v, string nm);
    int n;
    drive(v.port, 1'b1, v.we, v.addr, v.data);
    @(posedge clk);
    @(negedge clk);
    drive(v.port, 1'b0, 1'b0, '0, '0);
    n = 0;
    chk({nm, "_busy0"}, 32'(bsy(v.port)), 32'd1);
    while (!rdy(v.port) && n < 300) begin
      @(negedge clk);
      n++;
      if (v.mid && n == 3) drive(v.port, 1'b1, 1'b1, v.addr, 8'hFF);
      if (v.mid && n == 4) drive(v.port, 1'b0, 1'b0, '0, '0);
    end
    chk({nm, "_lat"},  32'(n), 32'(v.lat));
    chk({nm, "_q"},    32'(qq(v.port)), 32'(v.q));
    chk({nm, "_err"},  32'(er(v.port)), 32'(v.err));
    chk({nm, "_busy"}, 32'(bsy(v.port)), 32'd1);
    @(negedge clk);
    chk({nm, "_rdy_off"},  32'(rdy(v.port)), 32'd0);
    chk({nm, "_busy_off"}, 32'(bsy(v.port)), 32'd0);
    chk({nm, "_q_hold"},   32'(qq(v.port)), 32'(v.q));
    if (v.mid) begin
      @(negedge clk);
      chk({nm, "_ignored"}, 32'(bsy(v.port)), 32'd0);
    end
  endtask

  // Port A writes, port B reads or writes, both accepted on the same edge.
  task automatic dual(logic [AW-1:0] aa, logic [DW-1:0] da, bit wb, logic [AW-1:0] ab,
                      logic [DW-1:0] db, logic [DW-1:0] eqa, logic [DW-1:0] eqb, string nm);
    int n;
    drive(1'b0, 1'b1, 1'b1, aa, da);
    drive(1'b1, 1'b1, wb, ab, db);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    n = 0;
    while (!bus.ready_a && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_lat"}, 32'(n), 32'(RL));
    chk({nm, "_rdy_b"}, 32'(bus.ready_b), 32'd1);
    chk({nm, "_q_a"}, 32'(bus.q_a), 32'(eqa));
    chk({nm, "_q_b"}, 32'(bus.q_b), 32'(eqb));
    @(negedge clk);
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);

    //        port we  addr     data   lat  q      err mid
    tbl.push_back('{0, 1, AW'(3),  8'hA0, RL, 8'hA0, 0, 0});
    tbl.push_back('{0, 1, AW'(4),  8'hE0, SL, 8'hE0, 0, 0});
    tbl.push_back('{0, 0, AW'(3),  8'h00, RL, 8'hA0, 0, 1});
    tbl.push_back('{1, 0, AW'(3),  8'h00, RL, 8'hA0, 0, 0});
    tbl.push_back('{1, 0, AW'(4),  8'h00, SL, 8'hE0, 0, 0});
    tbl.push_back('{0, 0, OOR,     8'h00, RL, 8'h00, 1, 0});
    tbl.push_back('{0, 1, AW'(0),  8'h3C, RL, 8'h3C, 0, 0});
    tbl.push_back('{0, 1, TOP,     8'h5A, RL, 8'h5A, 0, 0});
    tbl.push_back('{0, 0, TOP,     8'h00, RL, 8'h5A, 0, 0});
    tbl.push_back('{0, 0, AW'(0),  8'h00, RL, 8'h3C, 0, 0});
    tbl.push_back('{0, 1, OOR,     8'h99, RL, 8'h00, 1, 0});
    tbl.push_back('{0, 1, AW'(32), 8'h77, RL, 8'h77, 0, 0});
    tbl.push_back('{0, 1, AW'(33), 8'h88, SL, 8'h88, 0, 0});

    #2;
    chk("rst_busy_a", 32'(bus.busy_a), 32'd0);
    chk("rst_rdy_a",  32'(bus.ready_a), 32'd0);
    chk("rst_q_a",    32'(bus.q_a), 32'd0);
    chk("rst_busy_b", 32'(bus.busy_b), 32'd0);
    chk("rst_err_b",  32'(bus.err_b), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) run(tbl[i], $sformatf("v%0d", i));

    dual(AW'(16), 8'h11, 1'b1, AW'(16), 8'h22, 8'h11, 8'h11, "ww_coll");
    run('{0, 0, AW'(16), 8'h00, RL, 8'h11, 0, 0}, "ww_read");
    dual(AW'(48), 8'h33, 1'b0, AW'(48), 8'h00, 8'h33, 8'h33, "wr_coll");

    // Abort a pending write of 55h to 20h with an asynchronous reset.
    drive(1'b0, 1'b1, 1'b1, AW'(32), 8'h55);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy_a", 32'(bus.busy_a), 32'd0);
    chk("arst_q_a",    32'(bus.q_a), 32'd0);
    chk("arst_rdy_a",  32'(bus.ready_a), 32'd0);
    chk("arst_q_b",    32'(bus.q_b), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run('{0, 0, AW'(33), 8'h00, RL, 8'h88, 0, 0}, "post_rst_first");
    run('{0, 0, AW'(32), 8'h00, RL, 8'h77, 0, 0}, "post_rst_20h");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
